// File: rtl/test_monitor.sv
// test_monitor: sticky per-test fail/finish collector with a registered pass/fail/timeout verdict
// Ports:
//   clock, reset (async, active-low)
//   start       level: 1 runs the tests, 0 returns a terminal state to IDLE
//   fail/finish per-test flags, bit i from test i
//   done/pass/timeout  registered verdict flags
//   fail_idx    lowest failing test index (valid in FAIL)
//   fail_seen/finish_seen  sticky flags for the current run
//   cycles      saturating RUN cycle count
// Build option: define TEST_MONITOR_TIMEOUT_EN to enable the watchdog (TOUT verdict).
module test_monitor #(
    parameter int N       = 5,
    parameter int CW      = 16,
    parameter int TIMEOUT = 1024,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  fail,
    input  logic [N-1:0]  finish,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [IW-1:0] fail_idx,
    output logic [N-1:0]  fail_seen,
    output logic [N-1:0]  finish_seen,
    output logic [CW-1:0] cycles
);
    typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TOUT} state_t;
    state_t state;
    logic [N-1:0] f, d;
    logic [IW-1:0] lo;
    logic [CW-1:0] cyc_nx;
    if (TIMEOUT < 1 || TIMEOUT > 2**CW - 1) begin : g_bad_timeout
        $error("test_monitor: TIMEOUT out of range");
    end
    // Descending scan so the lowest set bit wins.
    always_comb begin
        f = fail_seen | fail;
        d = finish_seen | finish;
        lo = '0;
        for (int i = N - 1; i >= 0; i--)
            if (f[i]) lo = IW'(i);
        cyc_nx = (cycles == '1) ? cycles : cycles + 1'b1;
    end
`ifdef TEST_MONITOR_TIMEOUT_EN
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);
`else
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            pass        <= 1'b0;
`ifdef TEST_MONITOR_TIMEOUT_EN
            timeout     <= 1'b0;
`endif
            fail_idx    <= '0;
            fail_seen   <= '0;
            finish_seen <= '0;
            cycles      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state       <= RUN;
                    fail_idx    <= '0;
                    fail_seen   <= '0;
                    finish_seen <= '0;
                    cycles      <= '0;
                end
                RUN: begin
                    fail_seen   <= f;
                    finish_seen <= d;
                    cycles      <= cyc_nx;
                    if (|f) begin
                        state    <= FAIL;
                        done     <= 1'b1;
                        fail_idx <= lo;
                    end else if (&d) begin
                        state <= PASS;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end
`ifdef TEST_MONITOR_TIMEOUT_EN
                    else if (cycles == TLIM) begin
                        state   <= TOUT;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
`endif
                end
                default: if (!start) begin
                    state <= IDLE;
                    done  <= 1'b0;
                    pass  <= 1'b0;
`ifdef TEST_MONITOR_TIMEOUT_EN
                    timeout <= 1'b0;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_test_monitor.sv
// tb_test_monitor: directed self-checking bench for test_monitor
module tb_test_monitor;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [4:0] fail = '0, finish = '0;
    logic done, pass, timeout;
    logic [2:0] fail_idx;
    logic [4:0] fail_seen, finish_seen;
    logic [15:0] cycles;
    logic start2 = 1'b0;
    logic [0:0] fail2 = '0, finish2 = '0;
    logic done2, pass2, timeout2;
    logic [0:0] fail_idx2, fail_seen2, finish_seen2;
    logic [3:0] cycles2;
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    test_monitor #(.N(5), .CW(16), .TIMEOUT(64)) dut (
        .clock(clock), .reset(reset), .start(start), .fail(fail), .finish(finish),
        .done(done), .pass(pass), .timeout(timeout), .fail_idx(fail_idx),
        .fail_seen(fail_seen), .finish_seen(finish_seen), .cycles(cycles)
    );

    test_monitor #(.N(1), .CW(4), .TIMEOUT(15)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .fail(fail2), .finish(finish2),
        .done(done2), .pass(pass2), .timeout(timeout2), .fail_idx(fail_idx2),
        .fail_seen(fail_seen2), .finish_seen(finish_seen2), .cycles(cycles2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #1;
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_tout", 32'(timeout), 0);
        chk("rst_idx", 32'(fail_idx), 0);
        chk("rst_fseen", 32'(fail_seen), 0);
        chk("rst_dseen", 32'(finish_seen), 0);
        chk("rst_cyc", 32'(cycles), 0);
        #10;
        reset = 1'b1;
        start = 1'b1;
        step();
        chk("run_done", 32'(done), 0);
        chk("run_cyc0", 32'(cycles), 0);
        for (int i = 0; i < 5; i++) begin
            finish = 5'(1 << i);
            step();
            if (i == 3) chk("pass_early", 32'(done), 0);
        end
        finish = '0;
        chk("pass_pass", 32'(pass), 1);
        chk("pass_done", 32'(done), 1);
        chk("pass_dseen", 32'(finish_seen), 32'h1f);
        chk("pass_cyc", 32'(cycles), 5);
        chk("pass_idx", 32'(fail_idx), 0);
        fail = 5'b10101;
        step(2);
        fail = '0;
        chk("hold_pass", 32'(pass), 1);
        chk("hold_fseen", 32'(fail_seen), 0);
        chk("hold_cyc", 32'(cycles), 5);
        start = 1'b0;
        step();
        chk("idle_done", 32'(done), 0);
        chk("idle_pass", 32'(pass), 0);
        chk("idle_dseen", 32'(finish_seen), 32'h1f);
        chk("idle_cyc", 32'(cycles), 5);
        start = 1'b1;
        step();
        chk("rerun_dseen", 32'(finish_seen), 0);
        chk("rerun_cyc", 32'(cycles), 0);
        fail = 5'b01100;
        finish = 5'b11111;
        step();
        fail = '0;
        finish = '0;
        chk("fp_done", 32'(done), 1);
        chk("fp_pass", 32'(pass), 0);
        chk("fp_idx", 32'(fail_idx), 2);
        chk("fp_fseen", 32'(fail_seen), 32'h0c);
        start = 1'b0;
        step();
        chk("fp_idle", 32'(done), 0);
        start = 1'b1;
        step();
        finish = 5'b01111;
        step(63);
        chk("to_early", 32'(done), 0);
        chk("to_cyc63", 32'(cycles), 63);
`ifdef TEST_MONITOR_TIMEOUT_EN
        step();
        chk("to_tout", 32'(timeout), 1);
        chk("to_done", 32'(done), 1);
        chk("to_cyc", 32'(cycles), 64);
`else
        step(137);
        chk("nto_done", 32'(done), 0);
        chk("nto_tout", 32'(timeout), 0);
        chk("nto_cyc", 32'(cycles), 200);
        finish = 5'b11111;
        step();
        chk("nto_pass", 32'(pass), 1);
`endif
        finish = '0;
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        finish = 5'b00011;
        step();
        finish = '0;
        step(9);
        chk("ar_cyc10", 32'(cycles), 10);
        chk("ar_dseen", 32'(finish_seen), 32'h03);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_cyc", 32'(cycles), 0);
        chk("ar_dseen0", 32'(finish_seen), 0);
        chk("ar_done", 32'(done), 0);
        reset = 1'b1;
        step();
        chk("ar_rerun0", 32'(cycles), 0);
        step();
        chk("ar_rerun1", 32'(cycles), 1);
        finish = 5'b00001;
        step();
        finish = '0;
        fail = 5'b01010;
        step();
        fail = '0;
        chk("ff_done", 32'(done), 1);
        chk("ff_pass", 32'(pass), 0);
        chk("ff_idx", 32'(fail_idx), 1);
        chk("ff_fseen", 32'(fail_seen), 32'h0a);
        chk("ff_dseen", 32'(finish_seen), 32'h01);
        start2 = 1'b1;
        step();
        step(14);
        chk("sat_cyc14", 32'(cycles2), 14);
        step(6);
        chk("sat_cyc15", 32'(cycles2), 15);
`ifdef TEST_MONITOR_TIMEOUT_EN
        chk("sat_tout", 32'(timeout2), 1);
`else
        chk("sat_done", 32'(done2), 0);
`endif
        start2 = 1'b0;
        step();
        start2 = 1'b1;
        step();
        fail2 = 1'b1;
        step();
        fail2 = 1'b0;
        chk("n1_done", 32'(done2), 1);
        chk("n1_fseen", 32'(fail_seen2), 1);
        chk("n1_idx", 32'(fail_idx2), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/test_monitor.md
Name: test_monitor

Overview:
Result collector that sits directly downstream of the per-test instances in a simulation top. It consumes their per-test fail/finish flags and latches them sticky. It runs a verdict state machine with a cycle counter and an optional watchdog, then presents a single registered pass/fail/timeout verdict to the top-level bench. The bench stops the simulation on that verdict instead of OR/AND-reducing the raw flags itself.

Parameters:
N, 5, number of test instances monitored (>=1)
CW, 16, width of run-cycle counter
TIMEOUT, 1024, RUN cycles allowed before timeout verdict (1 <= TIMEOUT <= 2^CW-1)

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  level; 1 = run tests, 0 = return to IDLE from a terminal state
fail  input  N  per-test fail pulses/levels, bit i from test i
finish  input  N  per-test finish pulses/levels, bit i from test i
done  output  1  1 in any terminal state (PASS/FAIL/TOUT)
pass  output  1  1 only in PASS
timeout  output  1  1 only in TOUT
fail_idx  output  max(1,$clog2(N))  lowest index of failing test, valid in FAIL
fail_seen  output  N  sticky fail bits for the current run
finish_seen  output  N  sticky finish bits for the current run
cycles  output  CW  RUN cycles elapsed, saturating

Behaviour:
- Reset (reset=0, async) state:
  - State = IDLE.
  - All outputs 0: done, pass, timeout, fail_idx, fail_seen, finish_seen, cycles.
- States: IDLE, RUN, PASS, FAIL, TOUT. All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - fail/finish are ignored.
  - start=1 -> RUN next edge; clear sticky vectors, cycles, fail_idx.
- RUN, each edge:
  - Form f = fail_seen|fail and d = finish_seen|finish. Register them as fail_seen/finish_seen.
  - cycles increments by 1, saturating at 2^CW-1.
- RUN transitions, priority highest first:
  1. f != 0 -> FAIL. fail_idx = lowest set bit of f.
  2. d all ones -> PASS.
  3. Timeout enabled and cycles == TIMEOUT-1 -> TOUT.
  4. Otherwise stay in RUN.
- Simultaneous events:
  - Fail and last finish on the same edge -> FAIL.
  - Fail on the timeout edge -> FAIL.
  - Completion on the timeout edge -> PASS.
- Latency: a flag sampled on edge k is reflected in done/pass at edge k (visible after k). done is never combinational.
- start dropping to 0 during RUN: no effect; the run continues to a verdict.
- Terminal states (PASS/FAIL/TOUT):
  - Hold all outputs, including sticky vectors and cycles. Inputs are ignored.
  - start=0 -> IDLE next edge; done/pass/timeout clear on that edge, sticky vectors and cycles hold.
  - start stays 1 -> hold indefinitely.
- reset asserted mid-RUN or in a terminal state: immediate return to the reset state, regardless of clock.
- A test that raises finish and later fail is still recorded as a fail, unless the verdict was already taken.
- N=1: fail_idx is 1 bit, always 0.

Optional Feature:
TEST_MONITOR_TIMEOUT_EN
- Defined: watchdog active as above; TOUT reachable, timeout output driven.
- Undefined: no TOUT state logic; timeout output tied 0. RUN persists until fail or full finish. cycles still counts and saturates.

Test Plan:
- Pass path (N=5, TIMEOUT=64, macro on): deassert reset, start=1. Pulse finish bits 0..4 one per cycle, each 1 cycle wide -> pass=1, done=1 at the edge of the 5th pulse. finish_seen=5'b11111, cycles=5, fail_idx=0.
- Fail priority: in RUN, assert fail=5'b01100 with finish=5'b11111 on the same edge -> FAIL, pass=0, done=1, fail_idx=2, fail_seen=5'b01100.
- Timeout: start=1, hold fail=0, finish=5'b01111 -> timeout=1, done=1 at edge 64, cycles=64. Rebuild with macro undefined -> still RUN at cycle 200, timeout=0.
- Terminal hold/return: after PASS, toggle fail bits with start=1 -> outputs unchanged. Drop start -> next edge done=0, state IDLE. Raise start -> sticky vectors and cycles cleared, new run begins.
- Async reset: mid-RUN at cycles=10, pull reset low between clock edges -> all outputs 0 immediately. Release reset with start=1 -> RUN resumes from cycles=0.
- Saturation: CW=4, TIMEOUT=15, macro undefined, no finish -> cycles reaches 15 and stays 15.
